// File: rtl/exc_sched.sv
// Exception/interrupt scheduler: arbitrates interrupt > exception > eret for the M stage
// and drives CP0 capture, pipeline flush and PC redirect, with a one-cycle HOLD after each redirect.
module exc_sched #(
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter int unsigned NINT       = 6
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [4:0]      ExcM,
   input  logic            ValidM,
   input  logic [31:0]     PCM,
   input  logic            EretM,
   input  logic [NINT-1:0] HWInt,
   input  logic [NINT-1:0] IM,
   input  logic            IE,
   input  logic            EXL,
   input  logic [31:0]     EPC,
   output logic            ExcValid,
   output logic [4:0]      ExcCode,
   output logic [31:0]     VPC,
   output logic            EXLClr,
   output logic            Flush,
   output logic            NPCSel,
   output logic [31:0]     NPC,
   output logic [NINT-1:0] IP,
   output logic [31:0]     TrapCnt
);

   typedef enum logic {RUN, HOLD} state_t;

   state_t          state_q, state_d;
   logic [NINT-1:0] ip_q;
   logic [31:0]     lastpc_q, lastpc_d;
   logic [31:0]     trapcnt_q, trapcnt_d;

   logic int_req, exc_req, eret_req;

   assign int_req  = (|(ip_q & IM)) & IE & ~EXL;
   assign exc_req  = ValidM & (ExcM != 5'd0) & ~EXL;
   assign eret_req = ValidM & EretM;

   always_comb begin
      state_d  = state_q;
      ExcValid = 1'b0;
      ExcCode  = '0;
      EXLClr   = 1'b0;
      Flush    = 1'b0;
      NPCSel   = 1'b0;
      NPC      = '0;
      unique case (state_q)
         RUN: begin
            if (int_req) begin
               ExcValid = 1'b1;
               Flush    = 1'b1;
               NPCSel   = 1'b1;
               NPC      = HANDLER_PC;
               state_d  = HOLD;
            end else if (exc_req) begin
               ExcValid = 1'b1;
               ExcCode  = ExcM;
               Flush    = 1'b1;
               NPCSel   = 1'b1;
               NPC      = HANDLER_PC;
               state_d  = HOLD;
            end else if (eret_req) begin
               EXLClr   = 1'b1;
               Flush    = 1'b1;
               NPCSel   = 1'b1;
               NPC      = EPC;
               state_d  = HOLD;
            end
         end
         HOLD: begin
            Flush   = 1'b1;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      // Reset forces every control output quiet, regardless of what M presents.
      if (Reset) begin
         ExcValid = 1'b0;
         ExcCode  = '0;
         EXLClr   = 1'b0;
         Flush    = 1'b0;
         NPCSel   = 1'b0;
         NPC      = '0;
      end
   end

   always_comb begin
      lastpc_d  = ValidM ? PCM : lastpc_q;
      trapcnt_d = ExcValid ? trapcnt_q + 32'd1 : trapcnt_q;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= RUN;
         ip_q      <= '0;
         lastpc_q  <= '0;
         trapcnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ip_q      <= HWInt;
         lastpc_q  <= lastpc_d;
         trapcnt_q <= trapcnt_d;
      end
   end

   assign VPC     = ValidM ? PCM : lastpc_q + 32'd4;
   assign IP      = ip_q;
   assign TrapCnt = trapcnt_q;

endmodule

// File: tb/tb_exc_sched.sv
// Directed bench for exc_sched: inputs driven on negedge, outputs checked #1 later.
module tb_exc_sched;

   logic        Clk = 1'b0;
   logic        Reset, ValidM, EretM, IE, EXL, ExcValid, EXLClr, Flush, NPCSel;
   logic [4:0]  ExcM, ExcCode;
   logic [31:0] PCM, EPC, VPC, NPC, TrapCnt;
   logic [5:0]  HWInt, IM, IP;

   int n_cmp  = 0;
   int n_fail = 0;

   exc_sched #(.HANDLER_PC(32'h0000_4180), .NINT(6)) dut (
      .Clk(Clk), .Reset(Reset), .ExcM(ExcM), .ValidM(ValidM), .PCM(PCM), .EretM(EretM),
      .HWInt(HWInt), .IM(IM), .IE(IE), .EXL(EXL), .EPC(EPC),
      .ExcValid(ExcValid), .ExcCode(ExcCode), .VPC(VPC), .EXLClr(EXLClr), .Flush(Flush),
      .NPCSel(NPCSel), .NPC(NPC), .IP(IP), .TrapCnt(TrapCnt)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic test_reset();
      Reset = 1'b1; ValidM = 1'b0; ExcM = '0; PCM = '0; EretM = 1'b0;
      HWInt = '0; IM = '0; IE = 1'b0; EXL = 1'b0; EPC = '0;
      tick(); tick();
      #1;
      n_cmp++; if (ExcValid !== 1'b0 || Flush !== 1'b0 || NPCSel !== 1'b0 || EXLClr !== 1'b0) begin
         n_fail++; $display("FAIL rst_ctrl: got ev=%0b fl=%0b ns=%0b ec=%0b want all 0", ExcValid, Flush, NPCSel, EXLClr); end
      n_cmp++; if (IP !== 6'd0 || TrapCnt !== 32'd0) begin
         n_fail++; $display("FAIL rst_regs: got IP=%h cnt=%h want 0/0", IP, TrapCnt); end
      n_cmp++; if (VPC !== 32'h4) begin
         n_fail++; $display("FAIL rst_vpc: got %h want 00000004", VPC); end
      @(negedge Clk);
      Reset = 1'b0;
      tick(); #1;
      n_cmp++; if (Flush !== 1'b0 || VPC !== 32'h4) begin
         n_fail++; $display("FAIL post_rst: got fl=%0b vpc=%h want 0/00000004", Flush, VPC); end
   endtask

   task automatic test_exception();
      ValidM = 1'b1; PCM = 32'h3000; ExcM = 5'd10;
      #1;
      n_cmp++; if (ExcValid !== 1'b1 || ExcCode !== 5'd10) begin
         n_fail++; $display("FAIL exc_take: got ev=%0b code=%0d want 1/10", ExcValid, ExcCode); end
      n_cmp++; if (VPC !== 32'h3000 || NPC !== 32'h4180 || Flush !== 1'b1 || NPCSel !== 1'b1) begin
         n_fail++; $display("FAIL exc_redir: got vpc=%h npc=%h fl=%0b ns=%0b want 3000/4180/1/1", VPC, NPC, Flush, NPCSel); end
      @(negedge Clk);
      ValidM = 1'b0; ExcM = '0;
      #1;
      n_cmp++; if (Flush !== 1'b1 || ExcValid !== 1'b0 || NPCSel !== 1'b0 || TrapCnt !== 32'd1) begin
         n_fail++; $display("FAIL exc_hold: got fl=%0b ev=%0b ns=%0b cnt=%0d want 1/0/0/1", Flush, ExcValid, NPCSel, TrapCnt); end
      @(negedge Clk); #1;
      n_cmp++; if (Flush !== 1'b0 || VPC !== 32'h3004) begin
         n_fail++; $display("FAIL exc_end: got fl=%0b vpc=%h want 0/00003004", Flush, VPC); end
      @(negedge Clk);
   endtask

   task automatic test_interrupt();
      ValidM = 1'b1; PCM = 32'h3008;
      tick();
      ValidM = 1'b0; IE = 1'b1; IM = 6'b000100; HWInt = 6'b000100;
      #1;
      n_cmp++; if (ExcValid !== 1'b0 || IP !== 6'd0) begin
         n_fail++; $display("FAIL int_early: got ev=%0b IP=%b want 0/000000", ExcValid, IP); end
      @(negedge Clk); #1;
      n_cmp++; if (IP !== 6'b000100 || ExcValid !== 1'b1 || ExcCode !== 5'd0) begin
         n_fail++; $display("FAIL int_take: got IP=%b ev=%0b code=%0d want 000100/1/0", IP, ExcValid, ExcCode); end
      n_cmp++; if (VPC !== 32'h300C || NPC !== 32'h4180) begin
         n_fail++; $display("FAIL int_vpc: got vpc=%h npc=%h want 0000300c/00004180", VPC, NPC); end
      @(negedge Clk);
      HWInt = '0;
      #1;
      n_cmp++; if (Flush !== 1'b1 || ExcValid !== 1'b0 || TrapCnt !== 32'd2) begin
         n_fail++; $display("FAIL int_hold: got fl=%0b ev=%0b cnt=%0d want 1/0/2", Flush, ExcValid, TrapCnt); end
      tick();
   endtask

   task automatic test_int_vs_exc();
      HWInt = 6'b000100;
      tick();
      ValidM = 1'b1; PCM = 32'h3020; ExcM = 5'd4;
      #1;
      n_cmp++; if (ExcValid !== 1'b1 || ExcCode !== 5'd0 || VPC !== 32'h3020) begin
         n_fail++; $display("FAIL int_vs_exc: got ev=%0b code=%0d vpc=%h want 1/0/3020", ExcValid, ExcCode, VPC); end
      @(negedge Clk);
      HWInt = '0; ValidM = 1'b0; ExcM = '0;
      tick(); #1;
      n_cmp++; if (TrapCnt !== 32'd3 || ExcValid !== 1'b0) begin
         n_fail++; $display("FAIL int_vs_exc_cnt: got cnt=%0d ev=%0b want 3/0", TrapCnt, ExcValid); end
      IE = 1'b0; IM = '0;
      @(negedge Clk);
   endtask

   task automatic test_exl_eret();
      EXL = 1'b1; ValidM = 1'b1; PCM = 32'h3030; ExcM = 5'd12;
      #1;
      n_cmp++; if (ExcValid !== 1'b0 || Flush !== 1'b0) begin
         n_fail++; $display("FAIL exl_block: got ev=%0b fl=%0b want 0/0", ExcValid, Flush); end
      @(negedge Clk);
      ExcM = '0; EretM = 1'b1; EPC = 32'h3010;
      #1;
      n_cmp++; if (EXLClr !== 1'b1 || NPC !== 32'h3010 || Flush !== 1'b1 || NPCSel !== 1'b1 || ExcValid !== 1'b0) begin
         n_fail++; $display("FAIL eret: got clr=%0b npc=%h fl=%0b ns=%0b ev=%0b want 1/3010/1/1/0", EXLClr, NPC, Flush, NPCSel, ExcValid); end
      @(negedge Clk);
      ValidM = 1'b0; EretM = 1'b0; EXL = 1'b0;
      #1;
      n_cmp++; if (Flush !== 1'b1 || EXLClr !== 1'b0 || TrapCnt !== 32'd3) begin
         n_fail++; $display("FAIL eret_hold: got fl=%0b clr=%0b cnt=%0d want 1/0/3", Flush, EXLClr, TrapCnt); end
      @(negedge Clk); #1;
      n_cmp++; if (Flush !== 1'b0) begin
         n_fail++; $display("FAIL eret_end: got fl=%0b want 0", Flush); end
      @(negedge Clk);
   endtask

   task automatic test_back_to_back();
      ValidM = 1'b1; PCM = 32'h3040; ExcM = 5'd10;
      #1;
      n_cmp++; if (ExcValid !== 1'b1) begin
         n_fail++; $display("FAIL b2b_c1: got ev=%0b want 1", ExcValid); end
      @(negedge Clk); #1;
      n_cmp++; if (ExcValid !== 1'b0 || Flush !== 1'b1) begin
         n_fail++; $display("FAIL b2b_c2: got ev=%0b fl=%0b want 0/1", ExcValid, Flush); end
      @(negedge Clk); #1;
      n_cmp++; if (ExcValid !== 1'b1 || ExcCode !== 5'd10) begin
         n_fail++; $display("FAIL b2b_c3: got ev=%0b code=%0d want 1/10", ExcValid, ExcCode); end
      @(negedge Clk);
      ValidM = 1'b0; ExcM = '0;
      tick(); #1;
      n_cmp++; if (TrapCnt !== 32'd5) begin
         n_fail++; $display("FAIL b2b_cnt: got %0d want 5", TrapCnt); end
      @(negedge Clk);
   endtask

   task automatic test_exc_eret();
      ValidM = 1'b1; PCM = 32'h3050; ExcM = 5'd10; EretM = 1'b1; EPC = 32'h3010;
      #1;
      n_cmp++; if (ExcValid !== 1'b1 || EXLClr !== 1'b0 || NPC !== 32'h4180) begin
         n_fail++; $display("FAIL exc_over_eret: got ev=%0b clr=%0b npc=%h want 1/0/4180", ExcValid, EXLClr, NPC); end
      @(negedge Clk);
      ValidM = 1'b0; ExcM = '0; EretM = 1'b0;
      tick();
   endtask

   task automatic test_wrap_and_hold_reset();
      force dut.trapcnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.trapcnt_q;
      #1;
      n_cmp++; if (TrapCnt !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", TrapCnt); end
      @(negedge Clk);
      ValidM = 1'b1; PCM = 32'h3060; ExcM = 5'd10; HWInt = 6'b111111;
      @(negedge Clk);
      ValidM = 1'b0; ExcM = '0;
      #1;
      n_cmp++; if (TrapCnt !== 32'd0 || Flush !== 1'b1) begin
         n_fail++; $display("FAIL wrap: got cnt=%h fl=%0b want 00000000/1", TrapCnt, Flush); end
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0; HWInt = '0;
      #1;
      n_cmp++; if (Flush !== 1'b0 || NPCSel !== 1'b0 || IP !== 6'd0) begin
         n_fail++; $display("FAIL hold_reset: got fl=%0b ns=%0b IP=%b want 0/0/000000", Flush, NPCSel, IP); end
   endtask

   initial begin
      @(negedge Clk);
      test_reset();
      test_exception();
      test_interrupt();
      test_int_vs_exc();
      test_exl_eret();
      test_back_to_back();
      test_exc_eret();
      test_wrap_and_hold_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
